gol_scanout: RTL and testbench
==============================

Name: gol_scanout

Overview:
Generation controller and readout engine for a WIDTH x HEIGHT Game of Life board built from cell instances.
- Snapshots the board's flattened alive vector.
- Streams the snapshot out one cell per beat in raster order over a valid/ready interface, for display, UART or debug capture.
- After the last beat is accepted, issues the single-cycle update pulse that advances every cell to the next generation.
- Sits between the cell array, which it consumes and steps, and any downstream sink.

Parameters:
WIDTH, 8, board columns (>=2)
HEIGHT, 8, board rows (>=2)
PERIOD, 1, minimum idle cycles after an update before the next snapshot (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
cells  input  WIDTH*HEIGHT  alive bits from the cell array; bit index = y*WIDTH+x
run  input  1  level: free-run generations continuously
step  input  1  single-cycle pulse: request exactly one frame+generation
update  output  1  single-cycle pulse to every cell's update input
out_valid  output  1  stream beat valid
out_ready  input  1  sink accepts beat
out_bit  output  1  alive bit of the current cell
out_sof  output  1  first beat of frame (x=0,y=0)
out_eol  output  1  last beat of row (x=WIDTH-1)
out_eof  output  1  last beat of frame (x=WIDTH-1,y=HEIGHT-1)
generation  output  16  count of update pulses issued, wraps 0xFFFF->0
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: state IDLE; update=0, out_valid=0, out_bit/sof/eol/eof=0, generation=0, busy=0; step_pend=0; x=y=0; hold counter=0. Reset mid-frame abandons the frame with no update pulse. The cells reset to their INIT values in the same cycle.
- step_pend: set by step in any state; cleared on entry to SNAP. At most one step is pending; extra pulses merge.
- IDLE: if run or step_pend, go to SNAP next cycle.
- SNAP, 1 cycle: snap <= cells; x=y=0; go to SCAN.
- SCAN:
  - out_valid=1. out_bit = snap[y*WIDTH+x]. Flags are decoded from x/y.
  - A beat transfers when out_valid && out_ready. On transfer, x increments; at x=WIDTH-1, x wraps to 0 and y increments.
  - On transfer of the eof beat, go to UPDATE. out_valid is 0 in the following cycle.
  - While out_valid && !out_ready, all out_* signals are held stable.
  - Deasserting run mid-frame does not abort the frame.
- UPDATE, 1 cycle: update=1; generation += 1; go to HOLD with the hold counter loaded to PERIOD-1.
- HOLD: counter decrements each cycle. At 0, go to SNAP if run or step_pend, else IDLE. This guarantees the cells' new state has settled before the next snapshot.
- Steady free-run with out_ready=1 and WIDTH*HEIGHT=N: update pulses are exactly 1+N+1+PERIOD cycles apart.
- Counter widths: $clog2(WIDTH) and $clog2(HEIGHT), minimum 1 bit. No combinational path from out_ready to out_valid.

Decomposition:
- Package gol_pkg holds:
  - the state enum (IDLE, SNAP, SCAN, UPDATE, HOLD);
  - a cell_index(x, y, width) function;
  - the GEN_W=16 constant.
- One natural sub-module: gol_raster_counter. It holds the x/y counter with an advance enable and exposes sof/eol/eof flags. It is reusable by a future pattern loader.

Test Plan:
1. Reset: assert rst 2 cycles with WIDTH=HEIGHT=3, PERIOD=2 -> update=0, out_valid=0, generation=0, busy=0.
2. Blinker step: cells=9'b000_111_000, out_ready=1, one step pulse -> 1 SNAP cycle, then 9 consecutive beats with bits 0,0,0,1,1,1,0,0,0; sof on beat 0, eol on beats 2/5/8, eof on beat 8; update high exactly one cycle after beat 8; generation=1; back to IDLE after 2 HOLD cycles.
3. Backpressure: same stimulus, out_ready toggling 1,0,0,1,... -> out_* stable during stalls, exactly 9 beats, update only after beat 8 transfers.
4. Free run with a real 3x3 cell array seeded with a blinker, run=1 -> frames alternate vertical/horizontal, update pulses exactly 13 cycles apart, generation counts 1,2,3,...
5. Reset mid-scan after 4 beats -> out_valid=0 the next cycle, no update pulse, generation=0, state IDLE.
6. Step merging: two step pulses during SCAN of a stepped frame -> exactly one additional frame and one extra update (generation=2), then IDLE.

Source files
------------

// File: rtl/gol_pkg.sv
// gol_pkg: shared states, constants and helpers for the Game of Life scanout engine
package gol_pkg;
  localparam int GEN_W = 16;
  typedef enum logic [2:0] {IDLE, SNAP, SCAN, UPDATE, HOLD} state_t;
  function automatic int cell_index(int x, int y, int width);
    return y * width + x;
  endfunction
  function automatic int cnt_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gol_scanout_if.sv
// gol_scanout_if: valid/ready cell stream carrying one alive bit plus frame flags
interface gol_scanout_if;
  logic out_valid;
  logic out_ready;
  logic out_bit;
  logic out_sof;
  logic out_eol;
  logic out_eof;
  modport master(output out_valid, out_bit, out_sof, out_eol, out_eof, input out_ready);
  modport slave(input out_valid, out_bit, out_sof, out_eol, out_eof, output out_ready);
endinterface

// File: rtl/gol_raster_counter.sv
// gol_raster_counter: raster-order x/y walker with frame position flags
module gol_raster_counter
  import gol_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HEIGHT = 8,
  localparam int XW = cnt_w(WIDTH),
  localparam int YW = cnt_w(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          sof,
  output logic          eol,
  output logic          eof
);
  assign sof = x == '0 && y == '0;
  assign eol = x == XW'(WIDTH - 1);
  assign eof = eol && y == YW'(HEIGHT - 1);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      x <= eol ? '0 : x + XW'(1);
      y <= eol ? (eof ? '0 : y + YW'(1)) : y;
    end
  end
endmodule

// File: rtl/gol_scanout.sv
// gol_scanout: snapshots the cell board, streams it in raster order, then steps one generation
module gol_scanout
  import gol_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HEIGHT = 8,
  parameter int PERIOD = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH*HEIGHT-1:0] cells,
  input  logic                    run,
  input  logic                    step,
  output logic                    update,
  output logic [GEN_W-1:0]        generation,
  output logic                    busy,
  gol_scanout_if.master           stream
);
  localparam int N = WIDTH * HEIGHT;
  localparam int XW = cnt_w(WIDTH);
  localparam int YW = cnt_w(HEIGHT);
  localparam int IW = cnt_w(N);
  localparam int HW = cnt_w(PERIOD);
  state_t state, state_nx;
  logic [N-1:0] snap;
  logic [HW-1:0] hold;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [IW-1:0] idx;
  logic step_pend, req, fire, sof, eol, eof;
  assign req = run | step_pend;
  assign fire = stream.out_valid & stream.out_ready;
  assign idx = IW'(cell_index(int'(x), int'(y), WIDTH));
  assign update = state == UPDATE;
  assign busy = state != IDLE;
  assign stream.out_valid = state == SCAN;
  assign stream.out_bit = stream.out_valid & snap[idx];
  assign stream.out_sof = stream.out_valid & sof;
  assign stream.out_eol = stream.out_valid & eol;
  assign stream.out_eof = stream.out_valid & eof;
  gol_raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) raster (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == SNAP),
    .advance(fire),
    .x      (x),
    .y      (y),
    .sof    (sof),
    .eol    (eol),
    .eof    (eof)
  );
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = req ? SNAP : IDLE;
      SNAP:    state_nx = SCAN;
      SCAN:    state_nx = fire && eof ? UPDATE : SCAN;
      UPDATE:  state_nx = HOLD;
      HOLD:    state_nx = hold != '0 ? HOLD : req ? SNAP : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // a step arriving on the very edge that enters SNAP is kept as a fresh request
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step_pend <= 1'b0;
      generation <= '0;
      hold <= '0;
      snap <= '0;
    end else begin
      state <= state_nx;
      step_pend <= step | (step_pend & (state_nx != SNAP));
      snap <= state == SNAP ? cells : snap;
      generation <= update ? generation + GEN_W'(1) : generation;
      hold <= update ? HW'(PERIOD - 1) : (state == HOLD && hold != '0) ? hold - HW'(1) : hold;
    end
  end
endmodule

// File: tb/tb_gol_scanout.sv
// tb_gol_scanout: directed, table-driven checks of framing, backpressure, free-run and reset
module tb_gol_scanout;
  import gol_pkg::*;
  localparam int W = 3;
  localparam int H = 3;
  localparam int N = W * H;
  localparam logic [N-1:0] HORIZ = 9'b000_111_000;
  localparam logic [N-1:0] VERT = 9'b010_010_010;
  typedef struct {
    logic [N-1:0] cells;
    logic [15:0]  ready;
    int           cycles;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, step = 1'b0, use_model = 1'b0;
  logic [N-1:0] cells_sig = '0, board, cells_in;
  logic update, busy;
  logic [GEN_W-1:0] generation;
  logic [3:0] cur;
  int errors = 0, checks = 0;
  vec_t vecs[4];
  gol_scanout_if bus();
  gol_scanout #(.WIDTH(W), .HEIGHT(H), .PERIOD(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cells     (cells_in),
    .run       (run),
    .step      (step),
    .update    (update),
    .generation(generation),
    .busy      (busy),
    .stream    (bus)
  );
  always #5 clk = ~clk;
  assign cells_in = use_model ? board : cells_sig;
  assign cur = {bus.out_bit, bus.out_sof, bus.out_eol, bus.out_eof};
  function automatic logic [N-1:0] life(input logic [N-1:0] b);
    logic [N-1:0] r;
    r = '0;
    for (int cy = 0; cy < H; cy++)
      for (int cx = 0; cx < W; cx++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if ((dx != 0 || dy != 0) && cx + dx >= 0 && cx + dx < W && cy + dy >= 0 && cy + dy < H)
              n += int'(b[(cy + dy) * W + cx + dx]);
        r[cy * W + cx] = n == 3 || (n == 2 && b[cy * W + cx]);
      end
    return r;
  endfunction
  // stands in for the real cell array: resets to a blinker, advances on update
  always_ff @(posedge clk) board <= rst ? HORIZ : update ? life(board) : board;
  function automatic logic [3:0] beat_exp(input logic [N-1:0] c, input int b);
    return {c[b], b == 0, b % W == W - 1, b == N - 1};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_frame(input vec_t v, input int gen);
    int beats, cyc;
    logic stalled;
    logic [3:0] prev;
    cells_sig = v.cells;
    bus.out_ready = 1'b0;
    step = 1'b1;
    tick;
    step = 1'b0;
    check("idle_after_step", busy, 0);
    tick;
    check("snap_cycle", {busy, bus.out_valid}, 2'b10);
    tick;
    beats = 0;
    cyc = 0;
    stalled = 1'b0;
    prev = '0;
    while (beats < N && cyc < 64) begin
      check("scan_valid", bus.out_valid, 1);
      check("no_early_update", update, 0);
      if (stalled) check("stall_stable", cur, prev);
      bus.out_ready = v.ready[cyc % 16];
      if (bus.out_ready) begin
        check($sformatf("beat%0d", beats), cur, beat_exp(v.cells, beats));
        beats++;
      end
      stalled = !bus.out_ready;
      prev = cur;
      tick;
      cyc++;
    end
    check("frame_cycles", cyc, v.cycles);
    check("update_pulse", {update, bus.out_valid}, 2'b10);
    check("gen_before", generation, gen - 1);
    tick;
    check("update_single", update, 0);
    check("gen_after", generation, gen);
    check("hold1_busy", busy, 1);
    tick;
    check("hold2_busy", busy, 1);
    tick;
    check("back_idle", busy, 0);
    bus.out_ready = 1'b1;
  endtask
  initial begin
    int ups, cyc, last, frames, bi;
    logic [N-1:0] fr;
    vecs[0] = '{HORIZ, 16'hFFFF, 9};
    vecs[1] = '{HORIZ, 16'h9999, 17};
    vecs[2] = '{VERT, 16'hFFFF, 9};
    vecs[3] = '{9'b101_000_101, 16'hAAAA, 18};
    bus.out_ready = 1'b0;
    tick;
    tick;
    check("rst_outputs", {update, bus.out_valid, busy, cur}, 0);
    check("rst_gen", generation, 0);
    rst = 1'b0;
    tick;
    check("idle_stays", busy, 0);
    for (int i = 0; i < 4; i++) run_frame(vecs[i], i + 1);
    cells_sig = HORIZ;
    step = 1'b1;
    tick;
    step = 1'b0;
    tick;
    tick;
    repeat (4) tick;
    check("pre_reset_beat4", {bus.out_valid, cur}, {1'b1, beat_exp(HORIZ, 4)});
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_gen", generation, 0);
    ups = 0;
    repeat (20) begin
      tick;
      ups += int'(update);
    end
    check("midrst_no_update", ups, 0);
    check("midrst_idle", busy, 0);
    step = 1'b1;
    tick;
    step = 1'b0;
    ups = 0;
    for (cyc = 1; cyc < 100; cyc++) begin
      tick;
      ups += int'(update);
      step = cyc == 4 || cyc == 7;
      if (!busy && cyc > 3) break;
    end
    step = 1'b0;
    check("merge_updates", ups, 2);
    check("merge_gen", generation, 2);
    repeat (10) tick;
    check("merge_idle", {busy, generation}, {1'b0, 16'd2});
    rst = 1'b1;
    use_model = 1'b1;
    run = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    ups = 0;
    last = 0;
    frames = 0;
    bi = 0;
    fr = '0;
    for (cyc = 0; cyc < 200 && ups < 4; cyc++) begin
      if (bus.out_valid) begin
        if (bus.out_sof) bi = 0;
        fr[bi] = bus.out_bit;
        bi = bi < N - 1 ? bi + 1 : bi;
        if (bus.out_eof) begin
          check($sformatf("free_frame%0d", frames), fr, frames % 2 ? VERT : HORIZ);
          frames++;
        end
      end
      if (update) begin
        check("free_gen", generation, ups);
        if (ups > 0) check("free_interval", cyc - last, 13);
        last = cyc;
        ups++;
      end
      tick;
    end
    check("free_updates", ups, 4);
    check("free_frames", frames, 4);
    run = 1'b0;
    for (cyc = 0; cyc < 40 && busy; cyc++) tick;
    check("free_stop_idle", busy, 0);
    check("free_gen_final", generation, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
